// File: rtl/rle_enc_param.sv
// ============================================================================
// Module   : rle_enc_param
// Brief    : Run-length encoder streaming symbols from dpsram, writing
//            packed {symbol,count} pairs back to dpsram.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rle_enc_param #(
  parameter int SYM_W   = 8,
  parameter int MAX_RUN = (1 << SYM_W) - 1,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  input  logic [31:0]       rle_addr,
  output logic [31:0]       rle_size,
  output logic              done,
  output logic              busy,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  input  logic [31:0]       port_A_data_out,
  output logic [31:0]       port_A_data_in,
  output logic              port_A_we
);

  localparam int SPW   = 32 / SYM_W;
  localparam int PW    = 2 * SYM_W;
  localparam int PPW   = 32 / PW;
  localparam int IW    = $clog2(SPW + 1);
  localparam int BW    = $clog2(PPW + 1);
  localparam int SHIFT = (SYM_W == 16) ? 1 : 0;
  localparam logic [SYM_W-1:0] MAX_CNT = SYM_W'(MAX_RUN);
  localparam logic [IW-1:0]    SPW_I   = IW'(SPW);
  localparam logic [BW-1:0]    PPW_B   = BW'(PPW);
  localparam logic [31:0]      BPP     = 32'(PW / 8);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, SCAN, EMIT, WRITE, FLUSH, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]       remain_q, remain_d, pairs_q, pairs_d;
  logic [31:0]       word_q, word_d, buf_q, buf_d;
  logic [IW-1:0]     sym_idx_q, sym_idx_d;
  logic [SYM_W-1:0]  cur_sym_q, cur_sym_d, count_q, count_d;
  logic              have_run_q, have_run_d;
  logic [BW-1:0]     buf_cnt_q, buf_cnt_d;

  logic [SYM_W-1:0]  sym;
  logic [31:0]       buf_app;
  logic [BW-1:0]     buf_cnt_inc;

  always_comb begin
    sym = '0;
    for (int s = 0; s < SPW; s++)
      if (sym_idx_q == IW'(s)) sym = word_q[s*SYM_W +: SYM_W];
  end

  // Current pair dropped into the next free slot, first pair in the low bits
  always_comb begin
    buf_app = buf_q;
    for (int p = 0; p < PPW; p++)
      if (buf_cnt_q == BW'(p)) buf_app[p*PW +: PW] = {cur_sym_q, count_q};
  end

  assign buf_cnt_inc = buf_cnt_q + BW'(1);

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    remain_d   = remain_q;
    pairs_d    = pairs_q;
    word_d     = word_q;
    buf_d      = buf_q;
    sym_idx_d  = sym_idx_q;
    cur_sym_d  = cur_sym_q;
    count_d    = count_q;
    have_run_d = have_run_q;
    buf_cnt_d  = buf_cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          rd_ptr_d   = message_addr;
          wr_ptr_d   = rle_addr;
          remain_d   = message_size >> SHIFT;
          pairs_d    = '0;
          buf_d      = '0;
          buf_cnt_d  = '0;
          sym_idx_d  = '0;
          count_d    = '0;
          have_run_d = 1'b0;
          state_d    = (message_size == 32'd0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        word_d    = port_A_data_out;
        rd_ptr_d  = rd_ptr_q + 32'd4;
        sym_idx_d = '0;
        state_d   = SCAN;
      end
      SCAN: begin
        if (remain_q == 32'd0) begin
          state_d = have_run_q ? EMIT : ((buf_cnt_q != '0) ? FLUSH : DONE);
        end else if (sym_idx_q == SPW_I) begin
          state_d = RD_REQ;
        end else if (!have_run_q) begin
          cur_sym_d  = sym;
          count_d    = SYM_W'(1);
          have_run_d = 1'b1;
          sym_idx_d  = sym_idx_q + IW'(1);
          remain_d   = remain_q - 32'd1;
        end else if (sym == cur_sym_q && count_q < MAX_CNT) begin
          count_d   = count_q + SYM_W'(1);
          sym_idx_d = sym_idx_q + IW'(1);
          remain_d  = remain_q - 32'd1;
        end else begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        buf_d     = buf_app;
        buf_cnt_d = buf_cnt_inc;
        pairs_d   = pairs_q + 32'd1;
        if (remain_q == 32'd0) begin
          have_run_d = 1'b0;
        end else begin
          // The symbol that broke the run opens the next one
          cur_sym_d = sym;
          count_d   = SYM_W'(1);
          sym_idx_d = sym_idx_q + IW'(1);
          remain_d  = remain_q - 32'd1;
        end
        if (buf_cnt_inc == PPW_B)      state_d = WRITE;
        else if (remain_q == 32'd0)    state_d = FLUSH;
        else                           state_d = SCAN;
      end
      WRITE: begin
        wr_ptr_d  = wr_ptr_q + 32'd4;
        buf_d     = '0;
        buf_cnt_d = '0;
        state_d   = (remain_q == 32'd0 && !have_run_q) ? DONE : SCAN;
      end
      FLUSH: begin
        wr_ptr_d  = wr_ptr_q + 32'd4;
        buf_d     = '0;
        buf_cnt_d = '0;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      remain_q   <= '0;
      pairs_q    <= '0;
      word_q     <= '0;
      buf_q      <= '0;
      sym_idx_q  <= '0;
      cur_sym_q  <= '0;
      count_q    <= '0;
      have_run_q <= 1'b0;
      buf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      remain_q   <= remain_d;
      pairs_q    <= pairs_d;
      word_q     <= word_d;
      buf_q      <= buf_d;
      sym_idx_q  <= sym_idx_d;
      cur_sym_q  <= cur_sym_d;
      count_q    <= count_d;
      have_run_q <= have_run_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

  assign port_A_clk     = clk;
  assign port_A_we      = (state_q == WRITE) || (state_q == FLUSH);
  assign port_A_data_in = port_A_we ? buf_q : 32'd0;
  assign done           = (state_q == DONE);
  assign busy           = (state_q != IDLE) && (state_q != DONE);
  assign rle_size       = pairs_q * BPP;

  always_comb begin
    port_A_addr = '0;
    if (state_q == RD_REQ)  port_A_addr = {rd_ptr_q[ADDR_W-1:2], 2'b00};
    else if (port_A_we)     port_A_addr = {wr_ptr_q[ADDR_W-1:2], 2'b00};
  end

endmodule

`default_nettype wire

// File: tb/tb_rle_enc_param.sv
// ============================================================================
// Module   : tb_rle_enc_param
// Brief    : Directed bench for rle_enc_param with 8- and 16-bit symbol DUTs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rle_enc_param;
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic start8, start16;
  logic [31:0] maddr8, msize8, raddr8, maddr16, msize16, raddr16;
  logic [31:0] rsize8, rsize16, rdata8, rdata16, wdata8, wdata16;
  logic done8, busy8, pclk8, we8, done16, busy16, pclk16, we16;
  logic [AW-1:0] paddr8, paddr16;

  logic        ld_en, ld_sel;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic [31:0]   mem8 [0:1023];
  logic [31:0]   mem16[0:1023];
  logic [AW-1:0] wlog_addr8[0:63], wlog_addr16[0:63];
  logic [31:0]   wlog_data8[0:63], wlog_data16[0:63];
  int wcnt8 = 0, wcnt16 = 0;
  int n_tests = 0, n_fail = 0;

  rle_enc_param #(.SYM_W(8), .ADDR_W(AW)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .message_addr(maddr8),
    .message_size(msize8), .rle_addr(raddr8), .rle_size(rsize8), .done(done8),
    .busy(busy8), .port_A_clk(pclk8), .port_A_addr(paddr8),
    .port_A_data_out(rdata8), .port_A_data_in(wdata8), .port_A_we(we8));

  rle_enc_param #(.SYM_W(16), .ADDR_W(AW)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .message_addr(maddr16),
    .message_size(msize16), .rle_addr(raddr16), .rle_size(rsize16), .done(done16),
    .busy(busy16), .port_A_clk(pclk16), .port_A_addr(paddr16),
    .port_A_data_out(rdata16), .port_A_data_in(wdata16), .port_A_we(we16));

  always @(posedge clk) begin
    rdata8  <= mem8[paddr8[AW-1:2]];
    rdata16 <= mem16[paddr16[AW-1:2]];
    if (we8) begin
      mem8[paddr8[AW-1:2]]    <= wdata8;
      wlog_addr8[wcnt8[5:0]]  <= paddr8;
      wlog_data8[wcnt8[5:0]]  <= wdata8;
      wcnt8 <= wcnt8 + 1;
    end
    if (we16) begin
      mem16[paddr16[AW-1:2]]   <= wdata16;
      wlog_addr16[wcnt16[5:0]] <= paddr16;
      wlog_data16[wcnt16[5:0]] <= wdata16;
      wcnt16 <= wcnt16 + 1;
    end
    if (ld_en && !ld_sel) mem8[ld_addr]  <= ld_data;
    if (ld_en && ld_sel)  mem16[ld_addr] <= ld_data;
  end

  task automatic load_word(input logic sel, input logic [31:0] baddr, input logic [31:0] data);
    ld_sel = sel; ld_addr = baddr[11:2]; ld_data = data; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run8(input logic [31:0] ma, input logic [31:0] ms, input logic [31:0] ra);
    maddr8 = ma; msize8 = ms; raddr8 = ra; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic run16(input logic [31:0] ma, input logic [31:0] ms, input logic [31:0] ra);
    maddr16 = ma; msize16 = ms; raddr16 = ra; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic wait_done(input logic sel, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((sel ? done16 : done8) === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({done8, busy8, we8, paddr8, wdata8, rsize8} !== '0) begin
      n_fail++;
      $display("FAIL reset_out8: got done=%b busy=%b we=%b addr=%h din=%h size=%0d, want all 0",
               done8, busy8, we8, paddr8, wdata8, rsize8);
    end
    n_tests++;
    if ({done16, busy16, we16, paddr16, wdata16, rsize16} !== '0) begin
      n_fail++;
      $display("FAIL reset_out16: got done=%b busy=%b we=%b addr=%h din=%h size=%0d, want all 0",
               done16, busy16, we16, paddr16, wdata16, rsize16);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_size;
    int base = wcnt8;
    bit ok = 1'b0;
    run8(32'h100, 32'd0, 32'h480);
    for (int i = 0; i < 2; i++) begin
      if (done8 === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL zero_done: done=%b after 2 cycles, want 1", done8); end
    repeat (3) @(negedge clk);
    n_tests++;
    if (wcnt8 - base !== 0) begin n_fail++; $display("FAIL zero_writes: got %0d writes, want 0", wcnt8 - base); end
    n_tests++;
    if (rsize8 !== 32'd0) begin n_fail++; $display("FAIL zero_size: got %0d, want 0", rsize8); end
  endtask

  task automatic test_basic;
    int base;
    load_word(1'b0, 32'h100, 32'h41414141);
    load_word(1'b0, 32'h104, 32'h42414141);
    base = wcnt8;
    run8(32'h100, 32'd8, 32'h400);
    wait_done(1'b0, 200, "basic");
    n_tests++;
    if (wcnt8 - base !== 1) begin n_fail++; $display("FAIL basic_nwr: got %0d, want 1", wcnt8 - base); end
    n_tests++;
    if (wlog_addr8[base[5:0]] !== 12'h400 || wlog_data8[base[5:0]] !== 32'h42014107) begin
      n_fail++;
      $display("FAIL basic_word: got %h@%h, want 42014107@400", wlog_data8[base[5:0]], wlog_addr8[base[5:0]]);
    end
    n_tests++;
    if (rsize8 !== 32'd4 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL basic_size: got size=%0d busy=%b, want 4/0", rsize8, busy8);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (done8 !== 1'b1) begin n_fail++; $display("FAIL basic_hold: done=%b, want 1", done8); end
  endtask

  task automatic test_long_run;
    int base;
    for (int i = 0; i < 75; i++) load_word(1'b0, 32'h200 + 32'(4*i), 32'h0);
    base = wcnt8;
    run8(32'h200, 32'd300, 32'h500);
    wait_done(1'b0, 2000, "long");
    n_tests++;
    if (wcnt8 - base !== 1 || wlog_addr8[base[5:0]] !== 12'h500 || wlog_data8[base[5:0]] !== 32'h002D00FF) begin
      n_fail++;
      $display("FAIL long_word: got %0d writes, %h@%h, want 1 write 002d00ff@500",
               wcnt8 - base, wlog_data8[base[5:0]], wlog_addr8[base[5:0]]);
    end
    n_tests++;
    if (rsize8 !== 32'd4) begin n_fail++; $display("FAIL long_size: got %0d, want 4", rsize8); end
  endtask

  task automatic test_partial;
    int base;
    logic [31:0] exp_d[3] = '{32'h33014401, 32'h11012201, 32'h00005501};
    logic [11:0] exp_a[3] = '{12'h600, 12'h604, 12'h608};
    load_word(1'b0, 32'h340, 32'h11223344);
    load_word(1'b0, 32'h344, 32'hAABBCC55);
    base = wcnt8;
    run8(32'h340, 32'd5, 32'h600);
    wait_done(1'b0, 200, "partial");
    n_tests++;
    if (wcnt8 - base !== 3) begin n_fail++; $display("FAIL partial_nwr: got %0d, want 3", wcnt8 - base); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (wlog_addr8[6'(base + i)] !== exp_a[i] || wlog_data8[6'(base + i)] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL partial_word%0d: got %h@%h, want %h@%h", i,
                 wlog_data8[6'(base + i)], wlog_addr8[6'(base + i)], exp_d[i], exp_a[i]);
      end
    end
    n_tests++;
    if (rsize8 !== 32'd10) begin n_fail++; $display("FAIL partial_size: got %0d, want 10", rsize8); end
  endtask

  task automatic test_sym16;
    int base;
    load_word(1'b1, 32'h100, 32'hBEEFBEEF);
    base = wcnt16;
    run16(32'h100, 32'd4, 32'h400);
    wait_done(1'b1, 200, "sym16");
    n_tests++;
    if (wcnt16 - base !== 1 || wlog_addr16[base[5:0]] !== 12'h400 || wlog_data16[base[5:0]] !== 32'hBEEF0002) begin
      n_fail++;
      $display("FAIL sym16_word: got %0d writes, %h@%h, want 1 write beef0002@400",
               wcnt16 - base, wlog_data16[base[5:0]], wlog_addr16[base[5:0]]);
    end
    n_tests++;
    if (rsize16 !== 32'd4) begin n_fail++; $display("FAIL sym16_size: got %0d, want 4", rsize16); end
  endtask

  task automatic test_reset_mid;
    int base = wcnt8;
    run8(32'h100, 32'd8, 32'h400);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({done8, busy8, we8, paddr8, wdata8, rsize8} !== '0) begin
      n_fail++;
      $display("FAIL midreset_out: got done=%b busy=%b we=%b addr=%h din=%h size=%0d, want all 0",
               done8, busy8, we8, paddr8, wdata8, rsize8);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (wcnt8 - base !== 0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL midreset_abort: got %0d writes done=%b, want 0/0", wcnt8 - base, done8);
    end
    run8(32'h100, 32'd8, 32'h400);
    @(negedge clk);
    n_tests++;
    if (busy8 !== 1'b1) begin n_fail++; $display("FAIL rerun_busy: busy=%b, want 1", busy8); end
    run8(32'h100, 32'd0, 32'h700);
    maddr8 = 32'h0; msize8 = 32'h0; raddr8 = 32'h0;
    wait_done(1'b0, 200, "rerun");
    n_tests++;
    if (wcnt8 - base !== 1 || wlog_addr8[base[5:0]] !== 12'h400 || wlog_data8[base[5:0]] !== 32'h42014107) begin
      n_fail++;
      $display("FAIL rerun_word: got %0d writes, %h@%h, want 1 write 42014107@400",
               wcnt8 - base, wlog_data8[base[5:0]], wlog_addr8[base[5:0]]);
    end
    n_tests++;
    if (rsize8 !== 32'd4) begin n_fail++; $display("FAIL rerun_size: got %0d, want 4", rsize8); end
  endtask

  initial begin
    reset = 1'b1;
    start8 = 1'b0; start16 = 1'b0;
    maddr8 = '0; msize8 = '0; raddr8 = '0;
    maddr16 = '0; msize16 = '0; raddr16 = '0;
    ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    @(negedge clk);
    test_reset();
    test_zero_size();
    test_basic();
    test_long_run();
    test_partial();
    test_sym16();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
